// File: rtl/buffer_resizer.sv
`default_nettype none
// ============================================================================
// Module   : buffer_resizer
// Purpose  : Lane-granular width-converting stream buffer. Kept input lanes
//            are compacted into a circular lane FIFO and re-packed into
//            M_KEEP_WIDTH-lane output entries; a pop never crosses a lane
//            flagged last. Rejected pushes raise overflow, pops from an
//            empty FIFO raise underflow.
// Options  : BUFFER_STICKY_FLAGS_EN - when defined, overflow/underflow hold
//            at 1 until rst instead of pulsing for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module buffer_resizer #(
  parameter int S_KEEP_WIDTH = 3,
  parameter int M_KEEP_WIDTH = 2,
  parameter int T_DATA_WIDTH = 1,
  parameter int DEPTH_LANES  = 8,
  localparam int LANE_SZ          = T_DATA_WIDTH + 2,
  localparam int BUF_IN_ENTRY_SZ  = LANE_SZ * S_KEEP_WIDTH,
  localparam int BUF_OUT_ENTRY_SZ = LANE_SZ * M_KEEP_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        slave_entry_valid,
  input  logic [BUF_IN_ENTRY_SZ-1:0]  slave_entry,
  input  logic                        master_entry_ready,
  output logic [BUF_OUT_ENTRY_SZ-1:0] master_entry,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int PTR_W  = (DEPTH_LANES > 1) ? $clog2(DEPTH_LANES) : 1;
  localparam int CNT_W  = $clog2(DEPTH_LANES + 1);
  localparam int SLOT_W = T_DATA_WIDTH + 1;   // stored {last, data}

  // Storage and state
  logic [SLOT_W-1:0]           mem_q [DEPTH_LANES];
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [BUF_OUT_ENTRY_SZ-1:0] master_entry_q, master_entry_d;
  logic                        overflow_q, overflow_d;
  logic                        underflow_q, underflow_d;

  // Pop side
  int                          pop_cnt;
  logic                        pop_stop;

  // Push side
  int                          push_cnt;
  int                          free_slots;
  logic                        push_ok;
  logic                        ovf_evt;
  logic                        udf_evt;
  logic [S_KEEP_WIDTH-1:0]     wr_en;
  logic [PTR_W-1:0]            wr_addr [S_KEEP_WIDTH];

  // Pointer arithmetic: operands never exceed twice the depth, so one
  // conditional subtract is enough to wrap.
  function automatic logic [PTR_W-1:0] wrap(input int a);
    int b;
    b = (a >= DEPTH_LANES) ? (a - DEPTH_LANES) : a;
    return PTR_W'(b);
  endfunction

  // Pop: gather up to M_KEEP_WIDTH head lanes, stopping after the first last.
  always_comb begin
    pop_cnt        = 0;
    pop_stop       = 1'b0;
    master_entry_d = '0;
    for (int j = 0; j < M_KEEP_WIDTH; j++) begin
      if (master_entry_ready && !pop_stop && (j < int'(count_q))) begin
        master_entry_d[j*LANE_SZ +: LANE_SZ] = {1'b1, mem_q[wrap(int'(rd_ptr_q) + j)]};
        pop_cnt = pop_cnt + 1;
        if (mem_q[wrap(int'(rd_ptr_q) + j)][T_DATA_WIDTH]) begin
          pop_stop = 1'b1;
        end
      end
    end
    udf_evt = master_entry_ready && (count_q == '0);
  end

  // Push: compact kept lanes onto consecutive slots; admit all or nothing
  // against the space left after this cycle's pop.
  always_comb begin
    push_cnt = 0;
    wr_en    = '0;
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      wr_addr[i] = '0;
    end
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      if (slave_entry[i*LANE_SZ + LANE_SZ - 1]) begin
        wr_addr[i] = wrap(int'(wr_ptr_q) + push_cnt);
        wr_en[i]   = 1'b1;
        push_cnt   = push_cnt + 1;
      end
    end
    free_slots = DEPTH_LANES - int'(count_q) + pop_cnt;
    push_ok    = slave_entry_valid && (push_cnt > 0) && (push_cnt <= free_slots);
    ovf_evt    = slave_entry_valid && (push_cnt > free_slots);
  end

  // Next-state for pointers, occupancy, output entry and flags.
  always_comb begin
    rd_ptr_d = (pop_cnt > 0) ? wrap(int'(rd_ptr_q) + pop_cnt) : rd_ptr_q;
    wr_ptr_d = push_ok ? wrap(int'(wr_ptr_q) + push_cnt) : wr_ptr_q;
    count_d  = CNT_W'(int'(count_q) - pop_cnt + (push_ok ? push_cnt : 0));
`ifdef BUFFER_STICKY_FLAGS_EN
    overflow_d  = overflow_q  | ovf_evt;
    underflow_d = underflow_q | udf_evt;
`else
    overflow_d  = ovf_evt;
    underflow_d = udf_evt;
`endif
  end

  // Control registers; reset wins over any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      master_entry_q <= '0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (master_entry_ready) begin
        master_entry_q <= master_entry_d;
      end
    end
  end

  // Lane storage; slots need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      if (!rst && push_ok && wr_en[i]) begin
        mem_q[wr_addr[i]] <= slave_entry[i*LANE_SZ +: SLOT_W];
      end
    end
  end

  assign master_entry = master_entry_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_buffer_resizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_buffer_resizer
// Purpose  : Directed, table-driven self-checking bench for buffer_resizer
//            at default parameters. Honours BUFFER_STICKY_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buffer_resizer;

`ifdef BUFFER_STICKY_FLAGS_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       slave_entry_valid;
  logic [8:0] slave_entry;
  logic       master_entry_ready;
  logic [5:0] master_entry;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_fail   = 0;

  buffer_resizer dut (
    .clk                (clk),
    .rst                (rst),
    .slave_entry_valid  (slave_entry_valid),
    .slave_entry        (slave_entry),
    .master_entry_ready (master_entry_ready),
    .master_entry       (master_entry),
    .overflow           (overflow),
    .underflow          (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [8:0] entry;
    logic       ready;
    logic [5:0] exp_me;
    logic       exp_ov;
    logic       exp_un;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic v, input logic [8:0] e,
                              input logic rd, input logic [5:0] me,
                              input logic ov, input logic un);
    vec_t t;
    t.rst = r; t.valid = v; t.entry = e; t.ready = rd;
    t.exp_me = me; t.exp_ov = ov; t.exp_un = un;
    vecs.push_back(t);
  endfunction

  // Drive one cycle of inputs and sample 1 time unit after the edge.
  task automatic step(input logic r, input logic v, input logic [8:0] e, input logic rd);
    @(negedge clk);
    rst = r; slave_entry_valid = v; slave_entry = e; master_entry_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] me, input logic ov, input logic un);
    n_checks++;
    if (master_entry !== me) begin
      n_fail++;
      $display("FAIL %s master_entry got %b expected %b", name, master_entry, me);
    end
    n_checks++;
    if (overflow !== ov) begin
      n_fail++;
      $display("FAIL %s overflow got %b expected %b", name, overflow, ov);
    end
    n_checks++;
    if (underflow !== un) begin
      n_fail++;
      $display("FAIL %s underflow got %b expected %b", name, underflow, un);
    end
  endtask

  initial begin
    rst = 1'b1; slave_entry_valid = 1'b0; slave_entry = '0; master_entry_ready = 1'b0;

    // Reset with traffic present, then packet split.
    add(1, 1, 9'b101100111, 1, 6'b000000, 0, 0);
    add(0, 1, 9'b101100111, 0, 6'b000000, 0, 0);
    add(0, 0, 9'b000000000, 1, 6'b000111, 0, 0);
    add(0, 0, 9'b000000000, 1, 6'b101100, 0, 0);
    add(0, 0, 9'b000000000, 1, 6'b000000, 0, 1);
    // Keep gaps: lanes 0 and 2 packed together; then ready=0 holds output.
    add(1, 0, 9'b000000000, 0, 6'b000000, 0, 0);
    add(0, 1, 9'b100000101, 0, 6'b000000, 0, 0);
    add(0, 0, 9'b000000000, 1, 6'b100101, 0, 0);
    add(0, 0, 9'b000000000, 0, 6'b100101, 0, 0);
    // Overflow: 3+3 accepted, third 3 rejected, 2 accepted, drain 8 lanes.
    add(1, 0, 9'b000000000, 0, 6'b000000, 0, 0);
    add(0, 1, 9'b100100100, 0, 6'b000000, 0, 0);
    add(0, 1, 9'b100100100, 0, 6'b000000, 0, 0);
    add(0, 1, 9'b100100100, 0, 6'b000000, 1, 0);
    add(0, 1, 9'b000100100, 0, 6'b000000, STK, 0);
    add(0, 0, 9'b000000000, 1, 6'b100100, STK, 0);
    add(0, 0, 9'b000000000, 1, 6'b100100, STK, 0);
    add(0, 0, 9'b000000000, 1, 6'b100100, STK, 0);
    add(0, 0, 9'b000000000, 1, 6'b100100, STK, 0);
    add(0, 0, 9'b000000000, 1, 6'b000000, STK, 1);
    add(0, 0, 9'b000000000, 0, 6'b000000, STK, STK);
    add(1, 0, 9'b000000000, 0, 6'b000000, 0, 0);
    // Zero-keep entry is a no-op, never an overflow.
    add(0, 1, 9'b011011011, 0, 6'b000000, 0, 0);
    add(0, 0, 9'b000000000, 1, 6'b000000, 0, 1);

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].rst, vecs[k].valid, vecs[k].entry, vecs[k].ready);
      check($sformatf("vec%0d", k), vecs[k].exp_me, vecs[k].exp_ov, vecs[k].exp_un);
    end

    // Concurrent push and pop: 7 lanes stored, then push 3 while popping 2.
    step(1, 0, 9'b000000000, 0);
    check("conc_rst", 6'b000000, 0, 0);
    step(0, 1, 9'b101100101, 0);
    step(0, 1, 9'b100101100, 0);
    step(0, 1, 9'b000000101, 0);
    check("conc_fill", 6'b000000, 0, 0);
    step(0, 1, 9'b111101100, 1);
    check("conc_both", 6'b100101, 0, 0);
    step(0, 0, 9'b000000000, 1);
    check("conc_pop1", 6'b100101, 0, 0);
    step(0, 0, 9'b000000000, 1);
    check("conc_pop2", 6'b100101, 0, 0);
    step(0, 0, 9'b000000000, 1);
    check("conc_pop3", 6'b100101, 0, 0);
    step(0, 0, 9'b000000000, 1);
    check("conc_pop4", 6'b111101, 0, 0);
    step(0, 0, 9'b000000000, 1);
    check("conc_empty", 6'b000000, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
